// File: rtl/moore_fsm_pkg.sv
// Shared definitions for the serial pattern detectors: state encoding, parameter limits,
// state-width helper and the prefix/suffix match test used by the next-state logic.
package moore_fsm_pkg;

    localparam int MAX_LEN   = 16;
    localparam int MIN_LEN   = 2;
    localparam int MAX_CNT_W = 32;
    localparam int MIN_CNT_W = 1;
    localparam int SW_MAX    = 5;

    // State index k = number of pattern prefix bits currently matched.
    typedef enum logic [SW_MAX-1:0] {
        S0,  S1,  S2,  S3,  S4,  S5,  S6,  S7,  S8,
        S9,  S10, S11, S12, S13, S14, S15, S16
    } st_t;

    function automatic int sw(input int len);
        return $clog2(len + 1);
    endfunction

    // hist[0] is the bit received just before x. pat is left-aligned: pat[MAX_LEN-1] is
    // the first pattern bit. True when the last k bits (ending with x) equal the k-bit prefix.
    function automatic logic pfx_match(input logic [MAX_LEN-2:0] hist,
                                       input logic               x,
                                       input logic [MAX_LEN-1:0] pat,
                                       input int                 k);
        logic [MAX_LEN-1:0] win;
        logic [MAX_LEN-1:0] pfx;
        logic [MAX_LEN-1:0] mask;
        win  = {hist, x};
        pfx  = pat >> (MAX_LEN - k);
        mask = ~({MAX_LEN{1'b1}} << k);
        if (k < 1 || k > MAX_LEN) begin
            return 1'b0;
        end
        return ((win ^ pfx) & mask) == '0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping; clear beats increment.
// Count updates one cycle after inc/clr; sat is a pure decode of the count.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = &count;

    always_ff @(posedge Clk) begin
        if (Reset || clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/moore_pattern_fsm.sv
// Moore serial detector: outp is high while the last PAT_LEN enabled bits equal a loadable pattern.
// outp rises the cycle after the completing bit; En=0 freezes state, history and counting.
module moore_pattern_fsm
    import moore_fsm_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    En,
    input  logic                    X,
    input  logic                    Pat_Load,
    input  logic [PAT_LEN-1:0]      Pat_In,
    input  logic                    Overlap,
    input  logic                    Cnt_Clr,
    output logic                    outp,
    output logic [sw(PAT_LEN)-1:0]  Estado_Salida,
    output logic [CNT_W-1:0]        Match_Count,
    output logic                    Cnt_Sat
);

    localparam int  SW      = sw(PAT_LEN);
    localparam st_t S_MATCH = st_t'(SW_MAX'(PAT_LEN));

    st_t                state;
    st_t                state_nxt;
    logic [PAT_LEN-1:0] pattern;
    logic [PAT_LEN-2:0] hist;
    logic [MAX_LEN-2:0] hist_ext;
    logic [MAX_LEN-1:0] pat_al;
    logic               cnt_inc;
    int                 limit;
    int                 nxt_k;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S0;
        end else if (Pat_Load) begin
            state <= S0;
        end else if (En) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pattern <= PATTERN;
            hist    <= '0;
        end else if (Pat_Load) begin
            pattern <= Pat_In;
            hist    <= '0;
        end else if (En) begin
            hist    <= (PAT_LEN-1)'({hist, X});
        end
    end

    // Longest pattern prefix that is a suffix of the received stream, never longer than
    // state+1; leaving S_MATCH without overlap only the new bit may start a fresh match.
    always_comb begin
        hist_ext                     = '0;
        hist_ext[PAT_LEN-2:0]        = hist;
        pat_al                       = '0;
        pat_al[MAX_LEN-1 -: PAT_LEN] = pattern;
        if (state == S_MATCH) begin
            limit = Overlap ? PAT_LEN : 1;
        end else begin
            limit = int'(state) + 1;
        end
        nxt_k = 0;
        for (int k = 1; k <= MAX_LEN; k++) begin
            if (k <= limit && pfx_match(hist_ext, X, pat_al, k)) begin
                nxt_k = k;
            end
        end
        state_nxt = st_t'(SW_MAX'(nxt_k));
    end

    assign outp          = (state == S_MATCH);
    assign Estado_Salida = SW'(state);
    assign cnt_inc       = En && !Pat_Load && (state_nxt == S_MATCH);

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (cnt_inc),
        .clr   (Cnt_Clr),
        .count (Match_Count),
        .sat   (Cnt_Sat)
    );

endmodule
